gh_fifo_rd_stream: RTL and testbench
====================================

# gh_fifo_rd_stream

Single-clock read-side engine for the asynchronous 16-deep FIFO. It drains the FIFO's pop interface (head word on Q, empty flag, RD strobe) and presents the words as a registered valid/ready stream framed into fixed-length bursts with start- and end-of-burst markers. A 2-entry skid buffer decouples the FIFO pop from downstream backpressure. The block sits in the FIFO's read clock domain and drives that FIFO's RD input directly.

## Interface
- data_width, 8, width of FIFO data and stream data
- burst_len, 4, words per burst; legal range 1..16

- clk  in  1  read-domain clock (same clock as the FIFO read side)
- rst_n  in  1  asynchronous, active-low reset
- srst  in  1  synchronous soft reset, active high
- en  in  1  run enable; stop request honoured only at burst boundaries
- fifo_Q  in  data_width  FIFO head word; valid whenever fifo_empty=0
- fifo_empty  in  1  FIFO empty flag
- fifo_RD  out  1  pop strobe; a pop occurs at a clk edge where fifo_RD=1 and fifo_empty=0
- m_data  out  data_width  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- m_sop  out  1  first word of a burst
- m_eop  out  1  last word of a burst
- busy  out  1  state is not IDLE or buffer not empty
- burst_cnt  out  16  completed bursts (counted on eop transfer), wraps at 2^16

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- FSM states are IDLE, RUN and STOP.
  - IDLE -> RUN when en=1.
  - RUN -> STOP when en=0 and the pop beat counter is not 0. RUN -> IDLE when en=0 and the pop beat counter is 0.
  - STOP -> IDLE on the pop that completes the burst (beat == burst_len-1).
  - STOP -> RUN if en=1 again before completion.
- fifo_RD = (state != IDLE) and fifo_empty=0 and buf_cnt < 2. It is purely combinational from registers and fifo_empty. It never depends on m_ready.
- Pop beat counter:
  - Width is 4 bits. It increments on each pop and wraps to 0 after burst_len-1.
  - The popped word is tagged sop = (beat == 0) and eop = (beat == burst_len-1).
  - When burst_len=1, every word carries both sop and eop.
- Skid buffer:
  - It has a main register (which drives the m_* outputs) and a skid register. buf_cnt ranges 0..2.
  - A transfer occurs at an edge where m_valid=1 and m_ready=1.
  - On a transfer, the main register loads from the skid register if it is occupied. Otherwise it loads the incoming pop. Otherwise it empties.
  - A pop arriving while the main register is held goes to the skid register.
- Stream rules:
  - m_data, m_sop and m_eop must stay stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a transfer.
- srst:
  - Clears both buffer entries and the beat counter, and moves the FSM to IDLE.
  - fifo_RD is forced to 0 during the srst cycle.
  - burst_cnt is not cleared.
- Reset values: m_valid=0, m_data=0, m_sop=0, m_eop=0, fifo_RD=0, busy=0, burst_cnt=0, state IDLE, beat=0, buf_cnt=0.

## Timing
- Latency: a word popped at edge k is on m_data with m_valid=1 from edge k onward, provided the main register is free or is transferring at edge k.
- Throughput: one word per clock when the FIFO is non-empty and m_ready=1 continuously. In steady state buf_cnt stays at 1.
- Backpressure: with m_ready=0, at most two further pops occur, and then fifo_RD=0.
- Simultaneous transfer, pop and skid occupied: main loads from skid, the popped word enters skid, and buf_cnt stays 2. This case cannot occur because fifo_RD=0 when buf_cnt=2. It is still coded defensively.
- fifo_empty rising in mid-burst: no pop occurs and the burst stays open. The beat counter is held, with no timeout.
- en=0 in mid-burst: pops continue until the eop word is popped, then the FSM enters IDLE. Words already buffered still drain.
- rst_n asserted mid-operation: all state clears immediately, asynchronously. Buffered words are lost.

## Configuration
- GH_RD_STREAM_PARITY_EN:
  - Defined: adds an output m_par (1 bit) carrying the even parity (XOR) of m_data. It is computed at pop time, stored in both buffer entries, reset value 0, and follows the same stability rule.
  - Undefined: the port and its storage are absent.

## Structure
- Shared package: the FSM state encoding (IDLE=2'b00, RUN=2'b01, STOP=2'b10) and the burst_cnt width constant (16).
- One sub-module: gh_skid_buf2 (the 2-entry valid/ready buffer, parameterised by payload width). The payload is data+sop+eop, plus par when GH_RD_STREAM_PARITY_EN is defined.

## Test plan
- burst_len=4, FIFO preloaded with 0x10..0x17, en=1, m_ready=1 -> 8 consecutive transfers of 0x10..0x17; sop on 0x10 and 0x14, eop on 0x13 and 0x17; burst_cnt=2.
- Same preload, m_ready=0 for 10 cycles -> exactly 2 pops, then fifo_RD=0; m_data=0x10 stable. Releasing m_ready -> order 0x10..0x17 with no loss or duplication.
- en dropped after the 2nd pop of a burst (burst_len=4) -> 2 more pops (eop on the 4th), then IDLE with fifo_RD=0 while the FIFO is still non-empty.
- FIFO empty after 0x20,0x21 with burst_len=4 -> burst held open. Writing 0x22,0x23 later -> eop on 0x23; burst_cnt increments once.
- srst with 2 words buffered -> next cycle m_valid=0, busy=0, beat=0. The next word popped carries sop=1. burst_cnt unchanged.
- rst_n pulsed low mid-burst -> all outputs read reset values asynchronously. With GH_RD_STREAM_PARITY_EN defined, 0x07 gives m_par=1.

Source files
------------

// File: rtl/gh_fifo_rd_stream_pkg.sv
// Shared types for the FIFO read-side stream engine: FSM encoding and counter width.
package gh_fifo_rd_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STOP = 2'b10
  } state_t;

  localparam int BURST_CNT_W = 16;

endpackage

// File: rtl/gh_fifo_rd_stream_if.sv
// Downstream stream bundle. m_par exists only when GH_RD_STREAM_PARITY_EN is defined.
// Handshake: a word transfers at a clk edge where m_valid=1 and m_ready=1; while
// m_valid=1 and m_ready=0 the payload is held stable and m_valid stays high.
interface gh_fifo_rd_stream_if #(
  parameter int data_width = 8
);
  logic [data_width-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_sop;
  logic                  m_eop;
`ifdef GH_RD_STREAM_PARITY_EN
  logic                  m_par;

  modport master (output m_data, m_valid, m_sop, m_eop, m_par, input m_ready);
  modport slave  (input m_data, m_valid, m_sop, m_eop, m_par, output m_ready);
`else
  modport master (output m_data, m_valid, m_sop, m_eop, input m_ready);
  modport slave  (input m_data, m_valid, m_sop, m_eop, output m_ready);
`endif
endinterface

// File: rtl/gh_fifo_rd_stream_skid_buf2.sv
// Two-entry valid/ready buffer: main register drives the output, skid register
// absorbs one word arriving while main is held.
module gh_skid_buf2 #(
  parameter int width = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [width-1:0] in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [width-1:0] out_data,
  output logic [1:0]       cnt
);

  logic             main_v;
  logic             skid_v;
  logic [width-1:0] main_d;
  logic [width-1:0] skid_d;
  logic             main_free;

  assign main_free = !main_v || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (clr) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (main_free) begin
      if (skid_v) begin
        // Skid word goes first; a simultaneous input refills the skid slot.
        main_v <= 1'b1;
        main_d <= skid_d;
        skid_v <= in_valid;
        if (in_valid) skid_d <= in_data;
      end else if (in_valid) begin
        main_v <= 1'b1;
        main_d <= in_data;
      end else begin
        main_v <= 1'b0;
      end
    end else if (in_valid && !skid_v) begin
      skid_v <= 1'b1;
      skid_d <= in_data;
    end
  end

  assign out_valid = main_v;
  assign out_data  = main_d;
  assign cnt       = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: rtl/gh_fifo_rd_stream.sv
// FIFO read-side engine: pops the FIFO and emits fixed-length bursts with sop/eop.
// Optional m_par output is enabled by defining GH_RD_STREAM_PARITY_EN.
module gh_fifo_rd_stream
  import gh_fifo_rd_stream_pkg::*;
#(
  parameter int data_width = 8,
  parameter int burst_len  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   srst,
  input  logic                   en,
  input  logic [data_width-1:0]  fifo_Q,
  input  logic                   fifo_empty,
  output logic                   fifo_RD,
  gh_fifo_rd_stream_if.master    m,
  output logic                   busy,
  output logic [BURST_CNT_W-1:0] burst_cnt,
  output state_t                 dbg_state,
  output logic [3:0]             dbg_beat
);

  localparam logic [3:0] LAST_BEAT = 4'(burst_len - 1);
`ifdef GH_RD_STREAM_PARITY_EN
  localparam int PW = data_width + 3;
`else
  localparam int PW = data_width + 2;
`endif

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      beat;
  logic [3:0]      beat_nxt;
  logic [1:0]      buf_cnt;
  logic            pop;
  logic            sop;
  logic            eop;
  logic [PW-1:0]   pop_payload;
  logic [PW-1:0]   out_payload;
  logic            out_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. Leaving RUN looks at the beat after this edge so a pop
  // that closes the burst in the same cycle lands directly in IDLE.
  always_comb begin
    state_nxt = state;
    if (srst) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (en) state_nxt = ST_RUN;
        ST_RUN:  if (!en) state_nxt = (beat_nxt == 4'd0) ? ST_IDLE : ST_STOP;
        ST_STOP: begin
          if (pop && beat == LAST_BEAT) state_nxt = ST_IDLE;
          else if (en)                  state_nxt = ST_RUN;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    fifo_RD = (state != ST_IDLE) && !fifo_empty && (buf_cnt < 2'd2) && !srst;
    busy    = (state != ST_IDLE) || (buf_cnt != 2'd0);
  end

  assign pop = fifo_RD;

  always_comb begin
    beat_nxt = beat;
    if (pop) beat_nxt = (beat == LAST_BEAT) ? 4'd0 : beat + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    beat <= 4'd0;
    else if (srst) beat <= 4'd0;
    else           beat <= beat_nxt;
  end

  assign sop = (beat == 4'd0);
  assign eop = (beat == LAST_BEAT);

`ifdef GH_RD_STREAM_PARITY_EN
  assign pop_payload = {^fifo_Q, sop, eop, fifo_Q};
`else
  assign pop_payload = {sop, eop, fifo_Q};
`endif

  gh_skid_buf2 #(.width(PW)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (srst),
    .in_valid  (pop),
    .in_data   (pop_payload),
    .out_ready (m.m_ready),
    .out_valid (out_valid),
    .out_data  (out_payload),
    .cnt       (buf_cnt)
  );

  assign m.m_valid = out_valid;
  assign m.m_data  = out_payload[data_width-1:0];
  assign m.m_eop   = out_payload[data_width];
  assign m.m_sop   = out_payload[data_width+1];
`ifdef GH_RD_STREAM_PARITY_EN
  assign m.m_par   = out_payload[data_width+2];
`endif

  // Bursts are counted when their eop word leaves; soft reset keeps the tally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) burst_cnt <= '0;
    else if (out_valid && m.m_ready && m.m_eop)
      burst_cnt <= burst_cnt + {{(BURST_CNT_W-1){1'b0}}, 1'b1};
  end

  assign dbg_state = state;
  assign dbg_beat  = beat;

endmodule

// File: tb/tb_gh_fifo_rd_stream.sv
// Directed bench for gh_fifo_rd_stream with a behavioural FIFO and a transfer monitor.
module tb_gh_fifo_rd_stream;
  import gh_fifo_rd_stream_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        srst;
  logic        en;
  logic [7:0]  fifo_Q;
  logic        fifo_empty;
  logic        fifo_RD;
  logic        busy;
  logic [15:0] burst_cnt;
  state_t      dbg_state;
  logic [3:0]  dbg_beat;

  int checks   = 0;
  int failures = 0;

  gh_fifo_rd_stream_if #(.data_width(8)) s_if ();

  gh_fifo_rd_stream #(.data_width(8), .burst_len(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .srst       (srst),
    .en         (en),
    .fifo_Q     (fifo_Q),
    .fifo_empty (fifo_empty),
    .fifo_RD    (fifo_RD),
    .m          (s_if),
    .busy       (busy),
    .burst_cnt  (burst_cnt),
    .dbg_state  (dbg_state),
    .dbg_beat   (dbg_beat)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural FIFO: words written at negedge, popped at posedge
  logic [7:0] fmem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  int         pop_cnt = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_Q     = fmem[rd_ptr];

  always @(posedge clk) begin
    if (fifo_RD && !fifo_empty) begin
      rd_ptr  <= rd_ptr + 8'd1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  // scoreboard capture of every stream transfer
  logic [7:0] rx_q[$];
  logic       rx_sop[$];
  logic       rx_eop[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    if (rst_n && s_if.m_valid && s_if.m_ready) begin
      rx_q.push_back(s_if.m_data);
      rx_sop.push_back(s_if.m_sop);
      rx_eop.push_back(s_if.m_eop);
    end
  end

  // driver tasks
  task automatic push_word(input logic [7:0] d);
    fmem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_sop.delete();
    rx_eop.delete();
    exp_q.delete();
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rx_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (rx_q.size() >= n) ok = 1'b1;
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0; srst = 1'b0; en = 1'b0; s_if.m_ready = 1'b0;
    cycles(2);
    checks++;
    if (s_if.m_valid !== 1'b0 || s_if.m_data !== 8'h00 || s_if.m_sop !== 1'b0 || s_if.m_eop !== 1'b0) begin
      failures++;
      $display("FAIL reset_stream got v=%b d=%h sop=%b eop=%b exp v=0 d=00 sop=0 eop=0",
               s_if.m_valid, s_if.m_data, s_if.m_sop, s_if.m_eop);
    end
    checks++;
    if (fifo_RD !== 1'b0 || busy !== 1'b0 || burst_cnt !== 16'd0 || dbg_state !== ST_IDLE || dbg_beat !== 4'd0) begin
      failures++;
      $display("FAIL reset_ctrl got rd=%b busy=%b cnt=%0d st=%0d beat=%0d exp all 0",
               fifo_RD, busy, burst_cnt, dbg_state, dbg_beat);
    end
    rst_n = 1'b1;
    cycles(1);
  endtask

  task automatic test_stream();
    bit ok;
    clear_rx();
    for (int i = 0; i < 8; i++) begin
      push_word(8'h10 + 8'(i));
      exp_q.push_back(8'h10 + 8'(i));
    end
    s_if.m_ready = 1'b1;
    en = 1'b1;
    wait_rx(8, 60, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stream_timeout got %0d words exp 8", rx_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= rx_q.size()) begin
        failures++;
        $display("FAIL stream_word%0d got none exp %h", i, exp_q[i]);
      end else if (rx_q[i] !== exp_q[i] || rx_sop[i] !== (i % 4 == 0) || rx_eop[i] !== (i % 4 == 3)) begin
        failures++;
        $display("FAIL stream_word%0d got d=%h sop=%b eop=%b exp d=%h sop=%b eop=%b",
                 i, rx_q[i], rx_sop[i], rx_eop[i], exp_q[i], (i % 4 == 0), (i % 4 == 3));
      end
    end
    checks++;
    if (burst_cnt !== 16'd2) begin
      failures++;
      $display("FAIL stream_burst_cnt got %0d exp 2", burst_cnt);
    end
    en = 1'b0;
    cycles(3);
    checks++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0) begin
      failures++;
      $display("FAIL stream_idle got st=%0d busy=%b exp st=0 busy=0", dbg_state, busy);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit stable;
    int p0;
    clear_rx();
    p0 = pop_cnt;
    for (int i = 0; i < 8; i++) begin
      push_word(8'h10 + 8'(i));
      exp_q.push_back(8'h10 + 8'(i));
    end
    s_if.m_ready = 1'b0;
    en = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s_if.m_valid && (s_if.m_data !== 8'h10 || s_if.m_sop !== 1'b1)) stable = 1'b0;
    end
    checks++;
    if (pop_cnt - p0 != 2) begin
      failures++;
      $display("FAIL bp_pops got %0d exp 2", pop_cnt - p0);
    end
    checks++;
    if (fifo_RD !== 1'b0 || s_if.m_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_stall got rd=%b valid=%b exp rd=0 valid=1", fifo_RD, s_if.m_valid);
    end
    checks++;
    if (!stable || s_if.m_data !== 8'h10) begin
      failures++;
      $display("FAIL bp_stable got d=%h stable=%b exp d=10 stable=1", s_if.m_data, stable);
    end
    s_if.m_ready = 1'b1;
    wait_rx(8, 60, ok);
    checks++;
    if (!ok || rx_q.size() != 8) begin
      failures++;
      $display("FAIL bp_count got %0d words exp 8", rx_q.size());
    end
    for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bp_order%0d got %h exp %h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (burst_cnt !== 16'd4) begin
      failures++;
      $display("FAIL bp_burst_cnt got %0d exp 4", burst_cnt);
    end
    en = 1'b0;
    cycles(3);
  endtask

  task automatic test_en_drop();
    bit ok;
    int p0;
    clear_rx();
    p0 = pop_cnt;
    for (int i = 0; i < 8; i++) push_word(8'h30 + 8'(i));
    s_if.m_ready = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (pop_cnt - p0 >= 2) break;
      @(negedge clk);
    end
    en = 1'b0;
    cycles(6);
    checks++;
    if (pop_cnt - p0 != 4) begin
      failures++;
      $display("FAIL endrop_pops got %0d exp 4", pop_cnt - p0);
    end
    checks++;
    if (dbg_state !== ST_IDLE || fifo_RD !== 1'b0 || fifo_empty !== 1'b0) begin
      failures++;
      $display("FAIL endrop_idle got st=%0d rd=%b empty=%b exp st=0 rd=0 empty=0",
               dbg_state, fifo_RD, fifo_empty);
    end
    checks++;
    if (rx_q.size() != 4 || rx_q[3] !== 8'h33 || rx_eop[3] !== 1'b1) begin
      failures++;
      $display("FAIL endrop_eop got n=%0d last=%h exp n=4 last=33 eop=1", rx_q.size(),
               (rx_q.size() > 0) ? rx_q[rx_q.size()-1] : 8'h00);
    end
    checks++;
    if (burst_cnt !== 16'd5) begin
      failures++;
      $display("FAIL endrop_burst_cnt got %0d exp 5", burst_cnt);
    end
    en = 1'b1;
    wait_rx(8, 40, ok);
    en = 1'b0;
    cycles(3);
    checks++;
    if (!ok || rx_q[4] !== 8'h34 || rx_sop[4] !== 1'b1 || burst_cnt !== 16'd6) begin
      failures++;
      $display("FAIL endrop_resume got n=%0d cnt=%0d exp n=8 cnt=6", rx_q.size(), burst_cnt);
    end
  endtask

  task automatic test_empty_hold();
    bit ok;
    logic [15:0] base;
    clear_rx();
    base = burst_cnt;
    push_word(8'h20);
    push_word(8'h21);
    s_if.m_ready = 1'b1;
    en = 1'b1;
    cycles(10);
    checks++;
    if (rx_q.size() != 2 || rx_sop[0] !== 1'b1 || dbg_beat !== 4'd2 || dbg_state !== ST_RUN || busy !== 1'b1) begin
      failures++;
      $display("FAIL hold_open got n=%0d beat=%0d st=%0d busy=%b exp n=2 beat=2 st=1 busy=1",
               rx_q.size(), dbg_beat, dbg_state, busy);
    end
    checks++;
    if (burst_cnt !== base) begin
      failures++;
      $display("FAIL hold_cnt got %0d exp %0d", burst_cnt, base);
    end
    push_word(8'h22);
    push_word(8'h23);
    wait_rx(4, 30, ok);
    cycles(2);
    checks++;
    if (!ok || rx_q[3] !== 8'h23 || rx_eop[3] !== 1'b1 || rx_eop[2] !== 1'b0) begin
      failures++;
      $display("FAIL hold_close got n=%0d exp n=4 last=23 eop=1", rx_q.size());
    end
    checks++;
    if (burst_cnt !== base + 16'd1) begin
      failures++;
      $display("FAIL hold_cnt_inc got %0d exp %0d", burst_cnt, base + 16'd1);
    end
    en = 1'b0;
    cycles(3);
  endtask

  task automatic test_srst();
    bit ok;
    int p0;
    logic [15:0] base;
    clear_rx();
    base = burst_cnt;
    p0 = pop_cnt;
    s_if.m_ready = 1'b0;
    en = 1'b1;
    push_word(8'h40);
    push_word(8'h41);
    push_word(8'h42);
    cycles(6);
    checks++;
    if (pop_cnt - p0 != 2 || busy !== 1'b1 || s_if.m_valid !== 1'b1) begin
      failures++;
      $display("FAIL srst_pre got pops=%0d busy=%b valid=%b exp 2 1 1", pop_cnt - p0, busy, s_if.m_valid);
    end
    srst = 1'b1;
    #1;
    checks++;
    if (fifo_RD !== 1'b0) begin
      failures++;
      $display("FAIL srst_rd got %b exp 0", fifo_RD);
    end
    @(negedge clk);
    srst = 1'b0;
    checks++;
    if (s_if.m_valid !== 1'b0 || busy !== 1'b0 || dbg_beat !== 4'd0 || burst_cnt !== base) begin
      failures++;
      $display("FAIL srst_clear got valid=%b busy=%b beat=%0d cnt=%0d exp 0 0 0 %0d",
               s_if.m_valid, busy, dbg_beat, burst_cnt, base);
    end
    s_if.m_ready = 1'b1;
    wait_rx(1, 20, ok);
    checks++;
    if (!ok || rx_q[0] !== 8'h42 || rx_sop[0] !== 1'b1) begin
      failures++;
      $display("FAIL srst_sop got n=%0d exp first=42 sop=1", rx_q.size());
    end
    push_word(8'h43);
    push_word(8'h44);
    push_word(8'h45);
    wait_rx(4, 30, ok);
    cycles(2);
    checks++;
    if (!ok || rx_eop[3] !== 1'b1 || burst_cnt !== base + 16'd1) begin
      failures++;
      $display("FAIL srst_burst got n=%0d cnt=%0d exp n=4 cnt=%0d", rx_q.size(), burst_cnt, base + 16'd1);
    end
    en = 1'b0;
    cycles(3);
  endtask

  task automatic test_async_reset();
    s_if.m_ready = 1'b0;
    en = 1'b1;
    push_word(8'h50);
    push_word(8'h51);
    cycles(5);
    checks++;
    if (s_if.m_valid !== 1'b1 || s_if.m_data !== 8'h50) begin
      failures++;
      $display("FAIL arst_pre got valid=%b d=%h exp 1 50", s_if.m_valid, s_if.m_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (s_if.m_valid !== 1'b0 || s_if.m_data !== 8'h00 || s_if.m_sop !== 1'b0 || s_if.m_eop !== 1'b0 ||
        busy !== 1'b0 || burst_cnt !== 16'd0 || dbg_state !== ST_IDLE || dbg_beat !== 4'd0) begin
      failures++;
      $display("FAIL arst_clear got v=%b d=%h busy=%b cnt=%0d st=%0d beat=%0d exp all 0",
               s_if.m_valid, s_if.m_data, busy, burst_cnt, dbg_state, dbg_beat);
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
`ifdef GH_RD_STREAM_PARITY_EN
    push_word(8'h07);
    en = 1'b1;
    cycles(4);
    checks++;
    if (s_if.m_valid !== 1'b1 || s_if.m_data !== 8'h07 || s_if.m_par !== 1'b1) begin
      failures++;
      $display("FAIL parity got v=%b d=%h par=%b exp 1 07 1", s_if.m_valid, s_if.m_data, s_if.m_par);
    end
    en = 1'b0;
    s_if.m_ready = 1'b1;
    cycles(3);
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_en_drop();
    test_empty_hold();
    test_srst();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
